// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder sequencer.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
// With RCA_SEQ_OVF_EN defined it also exposes c3, the carry into bit 3, for overflow detection.
module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic       c3
`endif
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1_s   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1_s;
  assign c2_s   = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2_s;
  assign c3_s   = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3_s;
  assign cout   = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));

`ifdef RCA_SEQ_OVF_EN
  assign c3 = c3_s;
`endif

endmodule

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle W-bit adder that sequences one shared 4-bit slice, LSB nibble first.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.
module rca_nibble_sequencer
  import rca_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SLICE_W*NIBBLES-1:0]   a,
  input  logic [SLICE_W*NIBBLES-1:0]   b,
  input  logic                         cin,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [SLICE_W*NIBBLES-1:0]   sum,
  output logic                         cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic                         ovf
`endif
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              carry_r;
  logic [W-1:0]      sum_r;
  logic              cout_r;

  logic [3:0]        nib_a_s;
  logic [3:0]        nib_b_s;
  logic [3:0]        nib_sum_s;
  logic              nib_cout_s;
  logic [W-1:0]      nib_mask_s;
  logic [W-1:0]      nib_ins_s;

  // The shift amount is idx*4; shifting avoids oversized part-select indices.
  assign nib_a_s    = 4'(a_r >> {idx_r, 2'b00});
  assign nib_b_s    = 4'(b_r >> {idx_r, 2'b00});
  assign nib_mask_s = W'(4'hF) << {idx_r, 2'b00};
  assign nib_ins_s  = W'(nib_sum_s) << {idx_r, 2'b00};

`ifdef RCA_SEQ_OVF_EN
  logic nib_c3_s;
  logic ovf_r;

  rca4_slice u_slice (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (nib_sum_s),
    .cout (nib_cout_s),
    .c3   (nib_c3_s)
  );
`else
  rca4_slice u_slice (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (nib_sum_s),
    .cout (nib_cout_s)
  );
`endif

  // Control FSM together with operand, carry, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r <= RUN;
            idx_r   <= '0;
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            sum_r   <= '0;
            cout_r  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_r   <= 1'b0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= (sum_r & ~nib_mask_s) | nib_ins_s;
          carry_r <= nib_cout_s;
          idx_r   <= idx_r + IDX_ONE;
          if (idx_r == IDX_LAST) begin
            state_r <= DONE;
            cout_r  <= nib_cout_s;
`ifdef RCA_SEQ_OVF_EN
            ovf_r   <= nib_c3_s ^ nib_cout_s;
`endif
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state_r == IDLE) || (state_r == DONE);
  assign busy  = (state_r == RUN);
  assign done  = (state_r == DONE);
  assign sum   = sum_r;
  assign cout  = cout_r;
`ifdef RCA_SEQ_OVF_EN
  assign ovf   = ovf_r;
`endif

endmodule
